serial_add_sub: RTL
===================

# serial_add_sub

Sequential digit-serial adder/subtractor, the parametrised successor to the library's combinational ripple subtractor. It consumes D operand bits per clock over N/D cycles, keeps a single registered carry between digits, and selects add or subtract per operation. It lives in the synthesis library for sequential garbled-circuit designs, where a narrow datapath reused over several clock cycles cuts the per-cycle gate count.

## Interface
- N, 8: width of A and of the result S; N ≥ M; N must be a multiple of D (elaboration error otherwise).
- M, N: width of B; B is zero-extended to N bits.
- D, 1: digit width, i.e. bits processed per cycle; 1 ≤ D ≤ N.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only on an edge where busy=0.
- sub  in  1  mode, sampled with start: 0 → A+B, 1 → A−B.
- A  in  N  minuend/addend, sampled with start.
- B  in  M  subtrahend/addend, sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result valid.
- S  out  N  result, mod 2^N.
- CO  out  1  carry out of bit N−1. In subtract mode, 1 means A ≥ B unsigned (no borrow).
- V  out  1  signed two's-complement overflow.
- Z  out  1  S == 0.

## Operation
- Idle (busy=0). On start=1: latch A, BB={0,B}, and sub. Complement BB when sub=1. Set carry register c=sub. Clear the digit counter. Go to Run.
- Run (busy=1). Each edge adds digit i of A, digit i of the operand, and c through a D-bit ripple. The D sum bits are shifted into the result shift register from the MSB side, LSB digit first. c takes the digit carry-out. The counter increments.
- On the edge that processes digit N/D−1:
  - S ← the full shifted result (the final digit included).
  - CO ← final carry.
  - V ← (a_msb == b'_msb) && (s_msb != a_msb), where b' is the complemented operand in subtract mode.
  - Z ← (full result == 0).
  - done ← 1, busy ← 0. Return to Idle.
- S, CO, V, Z change only at completion and hold the previous result during Run.
- start while busy=1 is ignored. A, B and sub are not re-sampled.
- start on the cycle where done=1 is accepted (busy=0 then). Back-to-back operations are possible with no idle gap.
- Arithmetic: S = (A + BB) mod 2^N, or (A + ~BB + 1) mod 2^N; bitwise identical to an N-bit ripple adder with CI = sub.
- D = N degenerates to a single-cycle registered operation.

## Timing
- Reset (async assert, any state): busy=0, done=0, S=0, CO=0, V=0, Z=0, counter=0, c=0. An operation in flight is aborted, and no done is produced for it.
- Latency: start sampled at edge k → busy=1 after edge k; done=1 and result valid after edge k+N/D.
- done is high for exactly one cycle, unless a new operation with N/D=1 completes on the next edge.
- Throughput: one operation per N/D cycles.
- Counter width: clog2(N/D), minimum 1 bit. It wraps to 0 at completion.
- Critical path: D-bit ripple plus shift register; independent of N.

## Test plan
- N=8, D=1, sub=1, A=8'd200, B=8'd55 → busy for 8 cycles; at done: S=8'd145, CO=1, V=0, Z=0; done high exactly 1 cycle.
- N=8, D=2, sub=1, A=8'd5, B=8'd9 → done after 4 edges: S=8'd252, CO=0 (borrow). Then sub=0, A=8'h7F, B=8'h01 → S=8'h80, CO=0, V=1.
- N=8, M=4, D=4, sub=1, A=8'd16, B=4'd15 → done after 2 edges: S=8'd1, CO=1. Then A=B=0, sub=1 → S=0, Z=1, CO=1.
- Busy-ignore and back-to-back, N=8, D=1:
  - start with A=10, B=3, sub=1; start pulsed again mid-run with other operands → result S=7; the second start has no effect.
  - start held high on the done cycle with A=1, B=1, sub=0 → next done 8 cycles later with S=2.
- Reset mid-operation: assert rst at cycle 3 of an 8-cycle run → all outputs 0 immediately (asynchronously); no done follows. A fresh start after release completes normally.
- Randomised: 1000 operations each for (N,D) = (8,1), (16,4), (32,32) → S/CO/V/Z match the reference model (A ± B mod 2^N, carry out at bit N), with latency exactly N/D.

Source files
------------

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - digit-serial adder/subtractor, D bits per clock over N/D cycles
module serial_add_sub #(
    parameter int N = 8,
    parameter int M = N,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] A,
    input  logic [M-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         CO,
    output logic         V,
    output logic         Z
);

    localparam int DIGITS = N / D;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    // Reject widths that cannot be split into whole digits
    if (D < 1 || D > N || (N % D) != 0 || M < 1 || M > N) begin : g_param_check
        $error("serial_add_sub: need 1 <= D <= N, N multiple of D, 1 <= M <= N");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  r_sr;
    logic [N-1:0]  r_full;
    logic [N-1:0]  bb;
    logic [D:0]    digit_sum;
    logic [D-1:0]  sum;
    logic          cout;
    logic          c;
    logic [CW-1:0] cnt;
    logic          last;

    assign busy = (state == RUN);
    assign last = (cnt == LAST);

    // B zero-extended to the full operand width
    always_comb begin
        bb        = '0;
        bb[M-1:0] = B;
    end

    // One digit of ripple addition; the new digit enters the result from the MSB side
    always_comb begin
        digit_sum = {1'b0, a_sr[D-1:0]} + {1'b0, b_sr[D-1:0]} + {{D{1'b0}}, c};
        sum       = digit_sum[D-1:0];
        cout      = digit_sum[D];
        r_full    = (r_sr >> D) | (N'(sum) << (N - D));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start only accepted while idle, run ends on the final digit
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand shifting, carry chaining and result capture on the final digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            r_sr <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            done <= 1'b0;
            S    <= '0;
            CO   <= 1'b0;
            V    <= 1'b0;
            Z    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_sr <= A;
                    b_sr <= sub ? ~bb : bb;
                    c    <= sub;
                    cnt  <= '0;
                end
            end else begin
                a_sr <= a_sr >> D;
                b_sr <= b_sr >> D;
                r_sr <= r_full;
                c    <= cout;
                if (last) begin
                    cnt  <= '0;
                    S    <= r_full;
                    CO   <= cout;
                    // Low digit now holds the operand MSBs
                    V    <= (a_sr[D-1] == b_sr[D-1]) && (sum[D-1] != a_sr[D-1]);
                    Z    <= (r_full == '0);
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
